// File: rtl/cfg_arb_pkg.sv
// Shared types and constants for the configuration port arbiter.
package cfg_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_HUNT   = 3'd2,
    ST_HEADER = 3'd3,
    ST_DATA   = 3'd4
  } cfg_arb_state_e;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

  // Source indices double as bit positions in the one-hot Grant vector.
  localparam int SRC_UART = 0;
  localparam int SRC_PAR  = 1;

  // One-hot grant vector for a source index.
  function automatic logic [1:0] src_onehot(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cfg_arb_stall_timer.sv
// Stall timer for the configuration port arbiter. Only instantiated when
// CFG_ARB_TIMEOUT_EN is defined. Counts consecutive cycles in which the
// locked source offers nothing, and flags the cycle that completes
// TimeoutCycles such cycles.
module cfg_arb_stall_timer #(
  parameter int TimeoutCycles = 1024,
  parameter int TimeoutWidth  = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,  // arbiter in HUNT, HEADER or DATA
  input  logic stall_i,   // granted source has Valid low this cycle
  output logic expire_o   // this is the TimeoutCycles-th stalled cycle
);

  localparam logic [TimeoutWidth-1:0] LastCount = TimeoutWidth'(TimeoutCycles - 1);

  logic [TimeoutWidth-1:0] cnt_q, cnt_d;

  assign expire_o = active_i && stall_i && (cnt_q == LastCount);

  // Count stalled cycles; any acceptance, inactivity or expiry restarts the count.
  always_comb begin
    cnt_d = '0;
    if (active_i && stall_i && !expire_o) cnt_d = cnt_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/config_port_arbiter.sv
// Two-source arbiter in front of the configuration FSM write port.
// Source 0 (UART words) and source 1 (parallel bus) are granted one at a
// time; a grant is held across whole configuration sessions and released
// only at a desync header (or, with CFG_ARB_TIMEOUT_EN defined, after a
// stall timeout).
//
// Handshake: a source word is accepted in a cycle where Sx_Valid && Sx_Ready.
// Sx_Ready is a function of registered state and Grant only, never of Valid.
// The downstream side has no handshake: each accepted word appears on
// WriteData with a one-cycle WriteStrobe in the following cycle.
import cfg_arb_pkg::*;

module config_port_arbiter #(
  parameter int NumberOfRows  = 16,
  parameter int desync_flag   = 20,
  parameter int TimeoutCycles = 1024,
  parameter int TimeoutWidth  = 16
) (
  input  logic           CLK,
  input  logic           RESETn,
  input  logic [31:0]    S0_Data,
  input  logic           S0_Valid,
  output logic           S0_Ready,
  input  logic [31:0]    S1_Data,
  input  logic           S1_Valid,
  output logic           S1_Ready,
  output logic [31:0]    WriteData,
  output logic           WriteStrobe,
  output logic           CfgReset,
  output logic [1:0]     Grant,
  output logic           Locked,
  output logic           TimeoutErr,
  input  logic           ClearErr,
  output cfg_arb_state_e DbgState
);

  localparam int RowW = $clog2(NumberOfRows + 1);

  cfg_arb_state_e  state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;       // source granted most recently
  logic [RowW-1:0] row_cnt_q, row_cnt_d;
  logic            cfg_reset_q, cfg_reset_d;
  logic [31:0]     wdata_q;
  logic            wstrobe_q;
  logic            active;
  logic            accept;
  logic [31:0]     acc_word;
  logic            pick;
  logic            timeout_hit;

  assign active   = (state_q == ST_HUNT) || (state_q == ST_HEADER) || (state_q == ST_DATA);
  assign S0_Ready = active && grant_q[SRC_UART];
  assign S1_Ready = active && grant_q[SRC_PAR];
  assign accept   = (S0_Valid && S0_Ready) || (S1_Valid && S1_Ready);
  assign acc_word = grant_q[SRC_PAR] ? S1_Data : S0_Data;
  // Round-robin: on a tie the source not granted last wins.
  assign pick     = (S0_Valid && S1_Valid) ? ~last_q : S1_Valid;

  assign WriteData   = wdata_q;
  assign WriteStrobe = wstrobe_q;
  assign CfgReset    = cfg_reset_q;
  assign Grant       = grant_q;
  assign Locked      = (state_q == ST_HEADER) || (state_q == ST_DATA);
  assign DbgState    = state_q;

`ifdef CFG_ARB_TIMEOUT_EN
  logic stall;
  logic terr_q;

  assign stall      = active && !(grant_q[SRC_PAR] ? S1_Valid : S0_Valid);
  assign TimeoutErr = terr_q;

  cfg_arb_stall_timer #(
    .TimeoutCycles(TimeoutCycles),
    .TimeoutWidth (TimeoutWidth)
  ) u_stall_timer (
    .clk_i   (CLK),
    .rst_ni  (RESETn),
    .active_i(active),
    .stall_i (stall),
    .expire_o(timeout_hit)
  );

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)          terr_q <= 1'b0;
    else if (timeout_hit) terr_q <= 1'b1;
    else if (ClearErr)    terr_q <= 1'b0;
  end
`else
  localparam int unused_timeout_cfg = TimeoutCycles + TimeoutWidth;
  logic unused_clear_err;

  assign unused_clear_err = ClearErr;
  assign timeout_hit      = 1'b0;
  assign TimeoutErr       = 1'b0;
`endif

  // Next-state logic: grant selection and sync/header/frame tracking.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    row_cnt_d   = row_cnt_q;
    cfg_reset_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Hold off one cycle while an abort pulse is on CfgReset so the
        // following grant pulse gives the config FSM a fresh rising edge.
        if (!cfg_reset_q && (S0_Valid || S1_Valid)) begin
          grant_d     = src_onehot(pick);
          cfg_reset_d = 1'b1;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: state_d = ST_HUNT;
      ST_HUNT: begin
        if (accept && (acc_word == SYNC_WORD)) state_d = ST_HEADER;
      end
      ST_HEADER: begin
        if (accept) begin
          if (acc_word[desync_flag]) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            last_d  = grant_q[SRC_PAR];
          end else begin
            row_cnt_d = RowW'(NumberOfRows);
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          row_cnt_d = row_cnt_q - 1'b1;
          if (row_cnt_q == RowW'(1)) state_d = ST_HEADER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stall timeout aborts the session and rotates priority.
    if (timeout_hit) begin
      state_d     = ST_IDLE;
      grant_d     = 2'b00;
      last_d      = grant_q[SRC_PAR];
      cfg_reset_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      row_cnt_q   <= '0;
      cfg_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      row_cnt_q   <= row_cnt_d;
      cfg_reset_q <= cfg_reset_d;
    end
  end

  // Forward every accepted word one cycle later.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wdata_q   <= '0;
      wstrobe_q <= 1'b0;
    end else begin
      wstrobe_q <= accept;
      if (accept) wdata_q <= acc_word;
    end
  end

endmodule

// File: doc/config_port_arbiter.md
# config_port_arbiter

Two-source arbiter that shares the single configuration write port of the fabric's configuration FSM between a UART-derived word stream (source 0) and an external parallel bus (source 1). It grants one source at a time, issues a restart pulse to the configuration FSM on each new grant, and tracks the sync/header/frame protocol so that a grant is released only at a desync header or on a stall. Frames from two sources are never interleaved. It sits directly in front of the configuration FSM's WriteData/WriteStrobe/Reset inputs.

## Interface
- NumberOfRows, 16, data words per frame after each header
- desync_flag, 20, header bit index that ends a configuration session
- TimeoutCycles, 1024, consecutive stalled cycles before a locked grant is forcibly released
- TimeoutWidth, 16, stall counter width; TimeoutCycles < 2**TimeoutWidth
- CLK  in  1  clock
- RESETn  in  1  asynchronous, active-low reset
- S0_Data  in  32  source 0 word
- S0_Valid  in  1  source 0 word valid
- S0_Ready  out  1  source 0 word accepted when S0_Valid && S0_Ready
- S1_Data / S1_Valid / S1_Ready  in/in/out  32/1/1  same for source 1
- WriteData  out  32  registered word to the config FSM
- WriteStrobe  out  1  registered one-cycle strobe per forwarded word
- CfgReset  out  1  one-cycle pulse to the config FSM Reset input (rising edge restarts it)
- Grant  out  2  one-hot granted source, 00 when idle
- Locked  out  1  high in HEADER or DATA
- TimeoutErr  out  1  sticky stall-timeout flag
- ClearErr  in  1  synchronous clear of TimeoutErr

## Operation
- States: IDLE, GRANT, HUNT, HEADER, DATA.
- IDLE: no Ready. If any Valid, pick a source by round-robin (the source not granted last wins on a tie; S0 wins after reset). Go to GRANT with Grant set.
- GRANT: one cycle. CfgReset=1, Ready low. Go to HUNT.
- HUNT, HEADER, DATA: Ready of the granted source = 1. Ready of the other source = 0. Every accepted word is forwarded.
- HUNT: an accepted word equal to 32'hFAB0_FAB1 moves to HEADER. Other words are forwarded and the state does not change.
- HEADER: an accepted word with bit desync_flag=1 moves to IDLE and records the last grant. Otherwise load RowCnt=NumberOfRows and move to DATA.
- DATA: each accepted word decrements RowCnt. The word accepted with RowCnt==1 moves to HEADER.
- The config FSM never back-pressures, so no downstream handshake exists.
- Simultaneous ClearErr and a new timeout: the set wins.

## Timing
- Reset values: WriteData=0, WriteStrobe=0, CfgReset=0, Grant=00, Locked=0, TimeoutErr=0, S0_Ready=S1_Ready=0, state IDLE, RowCnt=0, last grant = S1 (so S0 is preferred).
- Ready is combinational from registered state and Grant only. It never depends on Valid.
- A word accepted at cycle N gives WriteStrobe=1 and WriteData=word at N+1.
- Valid seen in IDLE at cycle N gives GRANT (CfgReset=1) at N+1. The first acceptance is possible at N+2.
- The CfgReset pulse and WriteStrobe are never high in the same cycle.
- After a desync header is accepted at N: IDLE at N+1. A new grant can be made at N+1, giving GRANT at N+2.
- Reset mid-frame: all state and outputs return to reset values immediately. No CfgReset is generated by the reset itself.

## Configuration
- Macro CFG_ARB_TIMEOUT_EN.
- Defined:
  - In HUNT, HEADER or DATA, a counter increments every cycle in which the granted source's Valid is low, and clears on any acceptance.
  - When the counter reaches TimeoutCycles: go to IDLE, set TimeoutErr, pulse CfgReset in the next cycle to abort the config FSM's partial frame, and rotate priority.
- Undefined:
  - No counter exists. A grant is held until a desync header arrives.
  - TimeoutErr is tied to 0 and ClearErr is ignored.

## Structure
- Package cfg_arb_pkg holds:
  - the state enum,
  - SYNC_WORD = 32'hFAB0_FAB1,
  - the source-index localparams SRC_UART=0 and SRC_PAR=1.
- Sub-module cfg_arb_stall_timer holds the stall counter and compare, instantiated only under CFG_ARB_TIMEOUT_EN.
- Everything else stays flat in config_port_arbiter.

## Test plan
- Single session: S0 sends FAB0_FAB1, a header 0x0000_0001, 16 data words, then a header with bit 20 set. Expect:
  - CfgReset pulses once, before any strobe.
  - 19 WriteStrobes, each one cycle after acceptance, with matching data.
  - Locked high from the first header to the desync.
  - Grant returns to 00.
- Contention: both Valid in IDLE after reset. Expect S0 granted and S1_Ready=0 until S0's desync. Then S1 is granted with a second CfgReset pulse.
- Mid-frame stall without timeout: S0 stalls 5000 cycles in DATA while S1 is Valid. Expect the grant held and no S1 acceptance. Resuming S0 completes the frame.
- Timeout (macro defined, TimeoutCycles=64): S0 stalls in DATA with RowCnt=7. Expect:
  - IDLE after 64 stalled cycles.
  - TimeoutErr=1 and a CfgReset pulse.
  - S1 granted next.
  - ClearErr clears TimeoutErr.
- HUNT garbage: S1 sends 0x1234_5678 and 0xFAB0_FAB0 before FAB0_FAB1. Expect all three forwarded, with the state reaching HEADER only after FAB0_FAB1.
- Async reset asserted in DATA: outputs go to reset values within the same cycle. Expect no strobe and no CfgReset until a new grant.
